// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared definitions for the data-RAM port arbiter: default RAM geometry,
//   the largest supported requester count, the requester-index type, the
//   per-port owner tag and a small index-wrap helper.
package mem_arb_pkg;

  localparam int ADDR_W    = 12;
  localparam int DATA_W    = 12;
  localparam int MEM_DEPTH = 4096;
  localparam int MAX_REQ   = 8;
  localparam int IDX_W     = 3;

  typedef logic [IDX_W-1:0] req_idx_t;

  // Owner tag that follows one RAM port access through the RAM latency.
  typedef struct packed {
    logic     valid;
    req_idx_t owner;
  } port_tag_t;

  // Index one past idx, wrapping at n requesters.
  function automatic req_idx_t next_idx(input req_idx_t idx, input int n);
    return (int'(idx) == n - 1) ? '0 : idx + req_idx_t'(1);
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2
//   Combinational two-winner round-robin picker. Scans the eligible mask
//   upward from rr_ptr (modulo N); the first eligible requester becomes
//   winner 1 and the second becomes winner 2.
// Ports:
//   eligible  in   N  requesters that may be granted this cycle
//   rr_ptr    in   3  scan start index (always < N)
//   gnt1      out  N  one-hot winner 1 (valid only with vld1)
//   gnt2      out  N  one-hot winner 2 (valid only with vld2)
//   vld1/vld2 out  1  winner present
module rr_pick2
  import mem_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] eligible,
  input  req_idx_t     rr_ptr,
  output logic [N-1:0] gnt1,
  output logic [N-1:0] gnt2,
  output logic         vld1,
  output logic         vld2
);

  localparam int PW = IDX_W + 1;
  typedef logic [PW-1:0] pos_t;

  logic [MAX_REQ-1:0] elig_w;
  req_idx_t           sel1;
  req_idx_t           sel2;
  pos_t               pos;

  // Widened so the 3-bit scan index always addresses a real bit.
  assign elig_w = MAX_REQ'(eligible);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    sel1 = '0;
    sel2 = '0;
    vld1 = 1'b0;
    vld2 = 1'b0;
    pos  = '0;
    for (int k = 0; k < N; k++) begin
      // rr_ptr + k is below 2N, so one conditional subtract is the modulo.
      pos = {1'b0, rr_ptr} + pos_t'(k);
      if (pos >= pos_t'(N)) pos = pos - pos_t'(N);
      if (elig_w[pos[IDX_W-1:0]]) begin
        if (!vld1) begin
          vld1 = 1'b1;
          sel1 = pos[IDX_W-1:0];
        end else if (!vld2) begin
          vld2 = 1'b1;
          sel2 = pos[IDX_W-1:0];
        end
      end
    end
  end

  always_comb begin
    gnt1 = '0;
    gnt2 = '0;
    for (int i = 0; i < N; i++) begin
      gnt1[i] = vld1 && (sel1 == req_idx_t'(i));
      gnt2[i] = vld2 && (sel2 == req_idx_t'(i));
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the two ports of the dual-port data RAM between REQ_COUNT
//   requesters. Each cycle up to two pending requests win (round robin),
//   the RAM port signals load from registers, and one cycle after the RAM
//   access each port's read data is routed back to its owner with rvalid.
//   Writes also return rvalid; the RAM reads after writing, so rdata is the
//   written value.
// Optional feature (macro MEM_ARB_CONFLICT_CHECK_EN): when defined, a port-2
//   candidate that hits the port-1 winner's address with either side
//   writing is held back and stays pending.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   req/req_we                  per-requester request and write flag
//   req_addr/req_wdata          flattened, requester i at [i*W +: W]
//   gnt                         one-cycle grant pulse
//   rvalid/rdata                one-cycle read-data return (flattened rdata)
//   mem_address*/datain*/write* registered RAM port drives
//   mem_dataout1/2              RAM registered read data
module mem_port_arbiter #(
  parameter int REQ_COUNT = 4,
  parameter int ADDR_W    = mem_arb_pkg::ADDR_W,
  parameter int DATA_W    = mem_arb_pkg::DATA_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [REQ_COUNT-1:0]        req,
  input  logic [REQ_COUNT-1:0]        req_we,
  input  logic [REQ_COUNT*ADDR_W-1:0] req_addr,
  input  logic [REQ_COUNT*DATA_W-1:0] req_wdata,
  output logic [REQ_COUNT-1:0]        gnt,
  output logic [REQ_COUNT-1:0]        rvalid,
  output logic [DATA_W*REQ_COUNT-1:0] rdata,
  output logic [ADDR_W-1:0]           mem_address1,
  output logic [ADDR_W-1:0]           mem_address2,
  output logic [DATA_W-1:0]           mem_datain1,
  output logic [DATA_W-1:0]           mem_datain2,
  output logic                        mem_write1,
  output logic                        mem_write2,
  input  logic [DATA_W-1:0]           mem_dataout1,
  input  logic [DATA_W-1:0]           mem_dataout2
);
  import mem_arb_pkg::*;

  req_idx_t               rr_ptr;
  req_idx_t               ptr_nxt;
  logic [REQ_COUNT-1:0]   eligible;
  logic [REQ_COUNT-1:0]   pick1;
  logic [REQ_COUNT-1:0]   pick2;
  logic                   pick1_vld;
  logic                   pick2_vld;
  logic                   conflict;
  logic                   port2_ok;
  req_idx_t               idx1;
  req_idx_t               idx2;
  logic [ADDR_W-1:0]      addr1;
  logic [ADDR_W-1:0]      addr2;
  logic [DATA_W-1:0]      wdata1;
  logic [DATA_W-1:0]      wdata2;
  logic                   we1;
  logic                   we2;
  logic [REQ_COUNT-1:0]   issue_vec;
  port_tag_t              tag1_q;
  port_tag_t              tag2_q;
  port_tag_t              rtag1_q;
  port_tag_t              rtag2_q;

  // A requester is excluded in its grant cycle; it must drop or replace
  // its request after seeing gnt.
  assign eligible = req & ~gnt;

  rr_pick2 #(.N(REQ_COUNT)) u_pick (
    .eligible (eligible),
    .rr_ptr   (rr_ptr),
    .gnt1     (pick1),
    .gnt2     (pick2),
    .vld1     (pick1_vld),
    .vld2     (pick2_vld)
  );

  // Select the winners' request fields.
  always_comb begin
    idx1   = '0;
    idx2   = '0;
    addr1  = '0;
    addr2  = '0;
    wdata1 = '0;
    wdata2 = '0;
    we1    = 1'b0;
    we2    = 1'b0;
    for (int i = 0; i < REQ_COUNT; i++) begin
      if (pick1[i]) begin
        idx1   = req_idx_t'(i);
        addr1  = req_addr[i*ADDR_W +: ADDR_W];
        wdata1 = req_wdata[i*DATA_W +: DATA_W];
        we1    = req_we[i];
      end
      if (pick2[i]) begin
        idx2   = req_idx_t'(i);
        addr2  = req_addr[i*ADDR_W +: ADDR_W];
        wdata2 = req_wdata[i*DATA_W +: DATA_W];
        we2    = req_we[i];
      end
    end
  end

`ifdef MEM_ARB_CONFLICT_CHECK_EN
  assign conflict = pick1_vld && pick2_vld && (addr1 == addr2) && (we1 || we2);
`else
  // The system guarantees no same-address pair; the RAM resolves it port-2-wins.
  assign conflict = 1'b0;
`endif

  assign port2_ok = pick2_vld && !conflict;

  // Pointer moves past the last requester actually granted.
  always_comb begin
    ptr_nxt = rr_ptr;
    if (port2_ok)       ptr_nxt = next_idx(idx2, REQ_COUNT);
    else if (pick1_vld) ptr_nxt = next_idx(idx1, REQ_COUNT);
  end

  // Owners of the accesses the RAM performs at the coming edge.
  always_comb begin
    issue_vec = '0;
    for (int i = 0; i < REQ_COUNT; i++) begin
      issue_vec[i] = (tag1_q.valid && tag1_q.owner == req_idx_t'(i)) ||
                     (tag2_q.valid && tag2_q.owner == req_idx_t'(i));
    end
  end

  // RAM read data is already registered, so routing is a plain mux.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < REQ_COUNT; i++) begin
      if (rtag1_q.valid && rtag1_q.owner == req_idx_t'(i))
        rdata[i*DATA_W +: DATA_W] = mem_dataout1;
      else if (rtag2_q.valid && rtag2_q.owner == req_idx_t'(i))
        rdata[i*DATA_W +: DATA_W] = mem_dataout2;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt          <= '0;
      rvalid       <= '0;
      rr_ptr       <= '0;
      mem_write1   <= 1'b0;
      mem_write2   <= 1'b0;
      mem_address1 <= '0;
      mem_address2 <= '0;
      mem_datain1  <= '0;
      mem_datain2  <= '0;
      tag1_q       <= '0;
      tag2_q       <= '0;
      rtag1_q      <= '0;
      rtag2_q      <= '0;
    end else begin
      gnt    <= pick1 | (port2_ok ? pick2 : '0);
      rr_ptr <= ptr_nxt;

      // Idle ports keep address/data and never write.
      mem_write1 <= pick1_vld && we1;
      if (pick1_vld) begin
        mem_address1 <= addr1;
        mem_datain1  <= wdata1;
      end
      mem_write2 <= port2_ok && we2;
      if (port2_ok) begin
        mem_address2 <= addr2;
        mem_datain2  <= wdata2;
      end

      tag1_q  <= '{valid: pick1_vld, owner: idx1};
      tag2_q  <= '{valid: port2_ok,  owner: idx2};
      rtag1_q <= tag1_q;
      rtag2_q <= tag2_q;
      rvalid  <= issue_vec;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Self-checking bench for mem_port_arbiter with a behavioural dual-port
//   RAM and a transaction-level reference model (rotation list + address
//   map) predicting grants, pointer, rvalid and rdata.
module tb_mem_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 12;
  localparam int DW = 12;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req, req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    gnt, rvalid;
  logic [DW*N-1:0] rdata;
  logic [AW-1:0]   mem_address1, mem_address2;
  logic [DW-1:0]   mem_datain1, mem_datain2;
  logic            mem_write1, mem_write2;
  logic [DW-1:0]   mem_dataout1, mem_dataout2;

  mem_port_arbiter #(.REQ_COUNT(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .gnt          (gnt),
    .rvalid       (rvalid),
    .rdata        (rdata),
    .mem_address1 (mem_address1),
    .mem_address2 (mem_address2),
    .mem_datain1  (mem_datain1),
    .mem_datain2  (mem_datain2),
    .mem_write1   (mem_write1),
    .mem_write2   (mem_write2),
    .mem_dataout1 (mem_dataout1),
    .mem_dataout2 (mem_dataout2)
  );

  always #5 clk = ~clk;

  // ---------------- dual-port RAM: write then read, port 2 wins ----------
  logic [DW-1:0] ram [0:4095];
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;
  logic          wr1, wr2;
  assign wr1 = mem_write1 && !reset;
  assign wr2 = mem_write2 && !reset;

  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else begin
      if (wr1) ram[mem_address1] <= mem_datain1;
      if (wr2) ram[mem_address2] <= mem_datain2;
    end
    mem_dataout1 <= (wr2 && mem_address2 == mem_address1) ? mem_datain2 :
                    wr1 ? mem_datain1 : ram[mem_address1];
    mem_dataout2 <= wr2 ? mem_datain2 :
                    (wr1 && mem_address1 == mem_address2) ? mem_datain1 : ram[mem_address2];
  end

  // ---------------- requester agents ------------------------------------
  bit   [N-1:0]  a_pend, a_we;
  logic [AW-1:0] a_addr  [N];
  logic [DW-1:0] a_wdata [N];

  // ---------------- reference model -------------------------------------
  bit   [N-1:0]  m_gnt, m_rvalid;
  int            m_ptr;
  logic [DW-1:0] m_rdata [N];
  bit            m_known [N];
  logic [DW-1:0] m_ret   [N];
  bit            m_ret_known [N];
  logic [DW-1:0] ref_mem [int];

  int errors = 0;
  int checks = 0;

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req[i]                 = a_pend[i];
      req_we[i]              = a_we[i];
      req_addr[i*AW +: AW]   = a_addr[i];
      req_wdata[i*DW +: DW]  = a_wdata[i];
    end
  endtask

  task automatic model_access(input int j);
    if (a_we[j]) begin
      ref_mem[int'(a_addr[j])] = a_wdata[j];
      m_ret[j]       = a_wdata[j];
      m_ret_known[j] = 1'b1;
    end else if (ref_mem.exists(int'(a_addr[j]))) begin
      m_ret[j]       = ref_mem[int'(a_addr[j])];
      m_ret_known[j] = 1'b1;
    end else begin
      m_ret[j]       = '0;
      m_ret_known[j] = 1'b0;
    end
  endtask

  // Predict the state after the coming edge from the current inputs.
  task automatic predict();
    int order[$];
    int p1, p2;
    bit g2;
    if (reset) begin
      m_gnt = '0; m_rvalid = '0; m_ptr = 0;
      for (int i = 0; i < N; i++) begin
        m_rdata[i] = '0; m_known[i] = 1'b1; m_ret[i] = '0; m_ret_known[i] = 1'b0;
      end
      return;
    end
    for (int i = 0; i < N; i++) begin
      m_rvalid[i] = m_gnt[i];
      m_rdata[i]  = m_gnt[i] ? m_ret[i] : '0;
      m_known[i]  = m_gnt[i] ? m_ret_known[i] : 1'b1;
    end
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (a_pend[j] && !m_gnt[j]) order.push_back(j);
    end
    m_gnt = '0;
    if (order.size() >= 1) begin
      p1 = order[0];
      m_gnt[p1] = 1'b1;
      model_access(p1);
      m_ptr = (p1 + 1) % N;
      if (order.size() >= 2) begin
        p2 = order[1];
        g2 = 1'b1;
`ifdef MEM_ARB_CONFLICT_CHECK_EN
        if (a_addr[p2] == a_addr[p1] && (a_we[p1] || a_we[p2])) g2 = 1'b0;
`endif
        if (g2) begin
          m_gnt[p2] = 1'b1;
          model_access(p2);
          m_ptr = (p2 + 1) % N;
        end
      end
    end
  endtask

  // One clock: drive, predict, advance to the next negedge, drop granted.
  task automatic tick();
    drive();
    predict();
    @(posedge clk);
    @(negedge clk);
    a_pend &= ~m_gnt;
  endtask

  // ---------------- tests ------------------------------------------------
  task automatic test_reset();
    reset  = 1'b1;
    a_pend = '1;
    a_we   = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({gnt, rvalid, mem_write1, mem_write2} !== '0) begin
        errors++;
        $display("FAIL reset_ctl cyc%0d: gnt=%b rvalid=%b w1=%b w2=%b, want all 0", c, gnt, rvalid, mem_write1, mem_write2);
      end
      checks++;
      if ({mem_address1, mem_address2, mem_datain1, mem_datain2, rdata} !== '0) begin
        errors++;
        $display("FAIL reset_data cyc%0d: a1=%h a2=%h d1=%h d2=%h rdata=%h, want 0", c, mem_address1, mem_address2, mem_datain1, mem_datain2, rdata);
      end
      checks++;
      if (dut.rr_ptr !== 3'd0) begin
        errors++;
        $display("FAIL reset_ptr cyc%0d: got %0d want 0", c, dut.rr_ptr);
      end
    end
    a_pend = '0;
    reset  = 1'b0;
    tick();
  endtask

  task automatic test_write_read_same_edge();
    a_we[0] = 1'b1; a_addr[0] = 12'h010; a_wdata[0] = 12'hABC; a_pend[0] = 1'b1;
    a_we[1] = 1'b0; a_addr[1] = 12'h010; a_wdata[1] = 12'h000; a_pend[1] = 1'b1;
    tick();
`ifndef MEM_ARB_CONFLICT_CHECK_EN
    checks++;
    if (gnt !== 4'b0011) begin
      errors++; $display("FAIL wr_rd_gnt: got %b want 0011", gnt);
    end
    checks++;
    if (mem_write1 !== 1'b1 || mem_address1 !== 12'h010 || mem_datain1 !== 12'hABC) begin
      errors++;
      $display("FAIL wr_rd_port1: w1=%b a1=%h d1=%h want 1 010 abc", mem_write1, mem_address1, mem_datain1);
    end
    tick();
    checks++;
    if (rvalid !== 4'b0011) begin
      errors++; $display("FAIL wr_rd_rvalid: got %b want 0011", rvalid);
    end
    checks++;
    if (rdata[0*DW +: DW] !== 12'hABC || rdata[1*DW +: DW] !== 12'hABC) begin
      errors++;
      $display("FAIL wr_rd_rdata: r0=%h r1=%h want abc abc", rdata[0*DW +: DW], rdata[1*DW +: DW]);
    end
`else
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (gnt !== m_gnt || rvalid !== m_rvalid) begin
        errors++; $display("FAIL wr_rd_model cyc%0d: gnt=%b/%b rvalid=%b/%b", c, gnt, m_gnt, rvalid, m_rvalid);
      end
      if (rvalid[1]) begin
        checks++;
        if (rdata[1*DW +: DW] !== 12'hABC) begin
          errors++; $display("FAIL wr_rd_rdata1: got %h want abc", rdata[1*DW +: DW]);
        end
      end
      tick();
    end
`endif
    tick();
    tick();
  endtask

  task automatic test_round_robin();
    bit [N-1:0] exp_g [3];
    int         exp_p [3];
    bit [N-1:0] prev;
    exp_g[0] = 4'b0011; exp_g[1] = 4'b1100; exp_g[2] = 4'b0011;
    exp_p[0] = 2;       exp_p[1] = 0;       exp_p[2] = 2;
    reset = 1'b1; tick(); reset = 1'b0;
    checks++;
    if (dut.rr_ptr !== 3'd0) begin
      errors++; $display("FAIL rr_ptr_start: got %0d want 0", dut.rr_ptr);
    end
    for (int i = 0; i < N; i++) begin
      a_we[i] = 1'b0; a_addr[i] = AW'(i * 1024 + 32);
    end
    prev = '0;
    for (int c = 0; c < 4; c++) begin
      a_pend = '1;
      tick();
      if (c < 3) begin
        checks++;
        if (gnt !== exp_g[c]) begin
          errors++; $display("FAIL rr_gnt cyc%0d: got %b want %b", c, gnt, exp_g[c]);
        end
        checks++;
        if (int'(dut.rr_ptr) !== exp_p[c]) begin
          errors++; $display("FAIL rr_ptr cyc%0d: got %0d want %0d", c, dut.rr_ptr, exp_p[c]);
        end
      end
      checks++;
      if ((gnt & prev) !== '0) begin
        errors++; $display("FAIL rr_consecutive cyc%0d: gnt=%b prev=%b", c, gnt, prev);
      end
      prev = gnt;
    end
    a_pend = '0;
    tick();
    tick();
  endtask

`ifdef MEM_ARB_CONFLICT_CHECK_EN
  task automatic test_conflict();
    bit seen;
    reset = 1'b1; tick(); reset = 1'b0;
    a_we[2] = 1'b1; a_addr[2] = 12'h7FF; a_wdata[2] = 12'h5A5; a_pend[2] = 1'b1;
    a_we[3] = 1'b0; a_addr[3] = 12'h7FF;                       a_pend[3] = 1'b1;
    tick();
    checks++;
    if (gnt !== 4'b0100) begin
      errors++; $display("FAIL conflict_first: got %b want 0100", gnt);
    end
    seen = 1'b0;
    for (int c = 0; c < 4 && !seen; c++) begin
      tick();
      if (gnt === 4'b1000) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL conflict_second: gnt 1000 not seen, last gnt=%b", gnt);
    end
    tick();
    checks++;
    if (rvalid !== 4'b1000 || rdata[3*DW +: DW] !== 12'h5A5) begin
      errors++; $display("FAIL conflict_rdata: rvalid=%b r3=%h want 1000 5a5", rvalid, rdata[3*DW +: DW]);
    end
    tick();
  endtask
`endif

  task automatic test_reset_mid_op();
    a_we[0] = 1'b0; a_addr[0] = 12'h050; a_pend[0] = 1'b1;
    tick();
    checks++;
    if (gnt !== 4'b0001) begin
      errors++; $display("FAIL midrst_gnt: got %b want 0001", gnt);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({gnt, rvalid, mem_write1, mem_write2, mem_address1, mem_address2,
         mem_datain1, mem_datain2, rdata} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: gnt=%b rvalid=%b w=%b%b a1=%h a2=%h rdata=%h, want all 0",
               gnt, rvalid, mem_write1, mem_write2, mem_address1, mem_address2, rdata);
    end
    tick();
    checks++;
    if (rvalid !== '0) begin
      errors++; $display("FAIL midrst_late_rvalid: got %b want 0000", rvalid);
    end
  endtask

  task automatic test_single_req();
    pl_en = 1'b1; pl_addr = 12'hFFF; pl_data = 12'h123;
    ref_mem[int'(12'hFFF)] = 12'h123;
    tick();
    pl_en = 1'b0;
    a_we[3] = 1'b0; a_addr[3] = 12'hFFF; a_pend[3] = 1'b1;
    tick();
    checks++;
    if (gnt !== 4'b1000 || mem_address1 !== 12'hFFF || mem_write1 !== 1'b0 || mem_write2 !== 1'b0) begin
      errors++;
      $display("FAIL single_issue: gnt=%b a1=%h w1=%b w2=%b want 1000 fff 0 0", gnt, mem_address1, mem_write1, mem_write2);
    end
    tick();
    checks++;
    if (rvalid !== 4'b1000 || rdata[3*DW +: DW] !== 12'h123) begin
      errors++; $display("FAIL single_rdata: rvalid=%b r3=%h want 1000 123", rvalid, rdata[3*DW +: DW]);
    end
  endtask

  task automatic test_random_traffic();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!a_pend[i] && $urandom_range(0, 2) != 0) begin
          a_pend[i]  = 1'b1;
          a_we[i]    = 1'($urandom_range(0, 1));
          a_addr[i]  = AW'(i * 1024 + $urandom_range(0, 15));
          a_wdata[i] = DW'($urandom);
        end
      end
      tick();
      checks++;
      if (gnt !== m_gnt) begin
        errors++; $display("FAIL rand_gnt cyc%0d: got %b want %b", c, gnt, m_gnt);
      end
      checks++;
      if (rvalid !== m_rvalid) begin
        errors++; $display("FAIL rand_rvalid cyc%0d: got %b want %b", c, rvalid, m_rvalid);
      end
      checks++;
      if (int'(dut.rr_ptr) !== m_ptr) begin
        errors++; $display("FAIL rand_ptr cyc%0d: got %0d want %0d", c, dut.rr_ptr, m_ptr);
      end
      for (int i = 0; i < N; i++) begin
        if (m_rvalid[i] && m_known[i]) begin
          checks++;
          if (rdata[i*DW +: DW] !== m_rdata[i]) begin
            errors++; $display("FAIL rand_rdata%0d cyc%0d: got %h want %h", i, c, rdata[i*DW +: DW], m_rdata[i]);
          end
        end
      end
    end
    a_pend = '0;
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b1;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    a_pend = '0; a_we = '0;
    for (int i = 0; i < N; i++) begin
      a_addr[i] = '0; a_wdata[i] = '0; m_rdata[i] = '0; m_known[i] = 1'b1;
      m_ret[i] = '0; m_ret_known[i] = 1'b0;
    end
    m_gnt = '0; m_rvalid = '0; m_ptr = 0;
    drive();

    test_reset();
    test_write_read_same_edge();
    test_round_robin();
`ifdef MEM_ARB_CONFLICT_CHECK_EN
    test_conflict();
`endif
    test_reset_mid_op();
    test_single_req();
    test_random_traffic();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
